// File: rtl/eth_xcvr_link_supervisor_pkg.sv
// Shared lane state encoding, counter widths and a small helper for the link supervisor.
// Optional statistics are enabled with ETH_LINK_SUPERVISOR_STATS_EN.
package eth_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RST       = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_UP        = 3'd4,
        ST_HOLDOFF   = 3'd5,
        ST_FAIL      = 3'd6
    } lane_state_t;

    localparam int RETRY_W    = 8;
    localparam int DROP_CNT_W = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/eth_xcvr_link_supervisor_if.sv
// Per-lane status/control bundle between the PHY side and the link supervisor.
// link_drop_count only exists when ETH_LINK_SUPERVISOR_STATS_EN is defined.
interface eth_xcvr_link_supervisor_if #(
    parameter int NUM_LANES = 4
);
    import eth_link_pkg::*;

    logic [NUM_LANES-1:0]            lane_enable;
    logic [NUM_LANES-1:0]            gt_reset_rx_done;
    logic [NUM_LANES-1:0]            phy_rx_block_lock;
    logic [NUM_LANES-1:0]            phy_rx_high_ber;
    logic [NUM_LANES-1:0]            gt_reset_rx_datapath;
    logic [NUM_LANES-1:0]            link_up;
    logic [NUM_LANES-1:0]            link_fail;
    logic [RETRY_W*NUM_LANES-1:0]    retry_count;
`ifdef ETH_LINK_SUPERVISOR_STATS_EN
    logic [DROP_CNT_W*NUM_LANES-1:0] link_drop_count;
`endif

    // master = supervisor, slave = PHY / management side
    modport master (
        input  lane_enable,
        input  gt_reset_rx_done,
        input  phy_rx_block_lock,
        input  phy_rx_high_ber,
        output gt_reset_rx_datapath,
        output link_up,
        output link_fail,
        output retry_count
`ifdef ETH_LINK_SUPERVISOR_STATS_EN
        , output link_drop_count
`endif
    );

    modport slave (
        output lane_enable,
        output gt_reset_rx_done,
        output phy_rx_block_lock,
        output phy_rx_high_ber,
        input  gt_reset_rx_datapath,
        input  link_up,
        input  link_fail,
        input  retry_count
`ifdef ETH_LINK_SUPERVISOR_STATS_EN
        , input link_drop_count
`endif
    );

endinterface

// File: rtl/eth_xcvr_link_supervisor_lane_fsm.sv
// One lane of the RX link supervisor: input synchroniser, sequencing FSM, shared timer, retry counter.
// Drop statistics are built only with ETH_LINK_SUPERVISOR_STATS_EN.
//
//  state        | meaning
//  -------------+-----------------------------------------------------------
//  ST_IDLE      | lane disabled, all outputs low
//  ST_RST       | driving the GT RX datapath reset pulse
//  ST_WAIT_DONE | waiting for GT reset done, lock timer running
//  ST_WAIT_LOCK | waiting for block lock without high BER, timer restarted
//  ST_UP        | link up; timer counts consecutive high-BER cycles
//  ST_HOLDOFF   | back-off after a timeout or drop before the next reset
//  ST_FAIL      | retry limit reached; held until lane_enable drops
module eth_link_lane_fsm
    import eth_link_pkg::*;
#(
    parameter int RESET_PULSE_CYCLES = 16,
    parameter int LOCK_TIMEOUT       = 125000,
    parameter int HIGH_BER_CYCLES    = 1024,
    parameter int HOLDOFF_CYCLES     = 4096,
    parameter int MAX_RETRIES        = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               lane_enable_i,
    input  logic               gt_reset_rx_done_i,
    input  logic               phy_rx_block_lock_i,
    input  logic               phy_rx_high_ber_i,
    output logic               gt_reset_rx_datapath_o,
    output logic               link_up_o,
    output logic               link_fail_o,
    output logic [RETRY_W-1:0] retry_count_o
`ifdef ETH_LINK_SUPERVISOR_STATS_EN
    , output logic [DROP_CNT_W-1:0] link_drop_count_o
`endif
);

    localparam int TIMER_MAX = max_int(max_int(LOCK_TIMEOUT, HOLDOFF_CYCLES),
                                       max_int(HIGH_BER_CYCLES, RESET_PULSE_CYCLES));
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

    localparam logic [TIMER_W-1:0] RST_LOAD  = TIMER_W'(RESET_PULSE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCK_LOAD = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] BER_LOAD  = TIMER_W'(HIGH_BER_CYCLES - 1);
    localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLDOFF_CYCLES - 1);

    // {high_ber, block_lock, reset_done}
    logic [2:0] sync1_q, sync2_q;
    logic       done_s, lock_s, ber_s;

    lane_state_t        state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               gt_rst_q, link_up_q, link_fail_q;
    logic               fault, drop;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {phy_rx_high_ber_i, phy_rx_block_lock_i, gt_reset_rx_done_i};
            sync2_q <= sync1_q;
        end
    end

    assign done_s = sync2_q[0];
    assign lock_s = sync2_q[1];
    assign ber_s  = sync2_q[2];

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;
        fault   = 1'b0;
        drop    = 1'b0;
        if (!lane_enable_i) begin
            state_d = ST_IDLE;
            timer_d = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_RST;
                    timer_d = RST_LOAD;
                end
                ST_RST: begin
                    if (timer_q == '0) begin
                        state_d = ST_WAIT_DONE;
                        timer_d = LOCK_LOAD;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (done_s) begin
                        state_d = ST_WAIT_LOCK;
                        timer_d = LOCK_LOAD;
                    end else if (timer_q == '0) begin
                        fault = 1'b1;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s && !ber_s) begin
                        state_d = ST_UP;
                        timer_d = BER_LOAD;
                    end else if (timer_q == '0) begin
                        fault = 1'b1;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                ST_UP: begin
                    if (!lock_s || !done_s) begin
                        drop = 1'b1;
                    end else if (ber_s) begin
                        if (timer_q == '0) drop = 1'b1;
                        else               timer_d = timer_q - 1'b1;
                    end else begin
                        timer_d = BER_LOAD;
                    end
                    fault = drop;
                end
                ST_HOLDOFF: begin
                    if (timer_q == '0) begin
                        state_d = ST_RST;
                        timer_d = RST_LOAD;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                ST_FAIL: state_d = ST_FAIL;
                default: state_d = ST_IDLE;
            endcase

            if (fault) begin
                retry_d = (retry_q == {RETRY_W{1'b1}}) ? retry_q : retry_q + 1'b1;
                if ((MAX_RETRIES != 0) && (int'(retry_d) >= MAX_RETRIES)) begin
                    state_d = ST_FAIL;
                    timer_d = '0;
                end else begin
                    state_d = ST_HOLDOFF;
                    timer_d = HOLD_LOAD;
                end
            end
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            retry_q     <= '0;
            gt_rst_q    <= 1'b0;
            link_up_q   <= 1'b0;
            link_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            gt_rst_q    <= (state_d == ST_RST);
            link_up_q   <= (state_d == ST_UP);
            link_fail_q <= (state_d == ST_FAIL);
        end
    end

    assign gt_reset_rx_datapath_o = gt_rst_q;
    assign link_up_o              = link_up_q;
    assign link_fail_o            = link_fail_q;
    assign retry_count_o          = retry_q;

`ifdef ETH_LINK_SUPERVISOR_STATS_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    // Survives lane_enable toggles; only the block reset clears it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign link_drop_count_o = drop_cnt_q;
`endif

endmodule

// File: rtl/eth_xcvr_link_supervisor.sv
// Multi-lane RX link supervisor top: one independent lane FSM per lane plus output bus packing.
// Define ETH_LINK_SUPERVISOR_STATS_EN to add per-lane link_drop_count.
module eth_xcvr_link_supervisor
    import eth_link_pkg::*;
#(
    parameter int NUM_LANES          = 4,
    parameter int RESET_PULSE_CYCLES = 16,
    parameter int LOCK_TIMEOUT       = 125000,
    parameter int HIGH_BER_CYCLES    = 1024,
    parameter int HOLDOFF_CYCLES     = 4096,
    parameter int MAX_RETRIES        = 0
) (
    input  logic                        xcvr_ctrl_clk,
    input  logic                        xcvr_ctrl_rst,
    eth_xcvr_link_supervisor_if.master  bus
);

    logic [NUM_LANES-1:0]         gt_rst;
    logic [NUM_LANES-1:0]         up;
    logic [NUM_LANES-1:0]         fail;
    logic [RETRY_W*NUM_LANES-1:0] retry;
`ifdef ETH_LINK_SUPERVISOR_STATS_EN
    logic [DROP_CNT_W*NUM_LANES-1:0] drops;
`endif

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        eth_link_lane_fsm #(
            .RESET_PULSE_CYCLES (RESET_PULSE_CYCLES),
            .LOCK_TIMEOUT       (LOCK_TIMEOUT),
            .HIGH_BER_CYCLES    (HIGH_BER_CYCLES),
            .HOLDOFF_CYCLES     (HOLDOFF_CYCLES),
            .MAX_RETRIES        (MAX_RETRIES)
        ) u_lane (
            .clk_i                  (xcvr_ctrl_clk),
            .rst_i                  (xcvr_ctrl_rst),
            .lane_enable_i          (bus.lane_enable[i]),
            .gt_reset_rx_done_i     (bus.gt_reset_rx_done[i]),
            .phy_rx_block_lock_i    (bus.phy_rx_block_lock[i]),
            .phy_rx_high_ber_i      (bus.phy_rx_high_ber[i]),
            .gt_reset_rx_datapath_o (gt_rst[i]),
            .link_up_o              (up[i]),
            .link_fail_o            (fail[i]),
            .retry_count_o          (retry[RETRY_W*i +: RETRY_W])
`ifdef ETH_LINK_SUPERVISOR_STATS_EN
            , .link_drop_count_o    (drops[DROP_CNT_W*i +: DROP_CNT_W])
`endif
        );
    end

    assign bus.gt_reset_rx_datapath = gt_rst;
    assign bus.link_up              = up;
    assign bus.link_fail            = fail;
    assign bus.retry_count          = retry;
`ifdef ETH_LINK_SUPERVISOR_STATS_EN
    assign bus.link_drop_count      = drops;
`endif

endmodule

// File: tb/tb_eth_xcvr_link_supervisor.sv
// Directed scoreboard bench for eth_xcvr_link_supervisor with 2 lanes and short timers.
// Drop-counter checks are compiled in when ETH_LINK_SUPERVISOR_STATS_EN is defined.
module tb_eth_xcvr_link_supervisor;

    localparam int NL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_run = 0;
    int   n_fail = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    eth_xcvr_link_supervisor_if #(.NUM_LANES(NL)) bus();

    eth_xcvr_link_supervisor #(
        .NUM_LANES          (NL),
        .RESET_PULSE_CYCLES (4),
        .LOCK_TIMEOUT       (50),
        .HIGH_BER_CYCLES    (8),
        .HOLDOFF_CYCLES     (20),
        .MAX_RETRIES        (3)
    ) dut (
        .xcvr_ctrl_clk (clk),
        .xcvr_ctrl_rst (rst),
        .bus           (bus)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sbq.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] observed);
        exp_t e;
        n_run++;
        if (sbq.size() == 0) begin
            n_fail++;
            $error("FAIL sb_underflow: observed %0d, nothing expected", observed);
            return;
        end
        e = sbq.pop_front();
        assert (observed === e.val) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", e.tag, observed, e.val);
        end
    endtask

    function automatic logic sig(input int sel, input int ln);
        case (sel)
            0:       return bus.gt_reset_rx_datapath[ln];
            1:       return bus.link_up[ln];
            default: return bus.link_fail[ln];
        endcase
    endfunction

    // Returns the cycle at which the level was first seen, or -1 when the budget runs out.
    task automatic wait_lvl(input int sel, input int ln, input logic v, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (sig(sel, ln) === v) begin
                at = cyc;
                break;
            end
        end
    endtask

    function automatic logic [31:0] lane_snap(input int ln);
        return {21'd0, bus.gt_reset_rx_datapath[ln], bus.link_up[ln], bus.link_fail[ln],
                bus.retry_count[8*ln +: 8]};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s, rise, fall, r1, r2, r3, fl, at, g, b, seen;
        bus.lane_enable       = '0;
        bus.gt_reset_rx_done  = '0;
        bus.phy_rx_block_lock = '0;
        bus.phy_rx_high_ber   = '0;
        rst = 1'b1;
        tick(3);
        push("reset_lane0", 0);  sb_check(lane_snap(0));
        push("reset_lane1", 0);  sb_check(lane_snap(1));
`ifdef ETH_LINK_SUPERVISOR_STATS_EN
        push("reset_drops", 0);  sb_check(bus.link_drop_count);
`endif
        rst = 1'b0;
        tick(2);

        // 1: bring lane0 up
        push("t1_rise_latency", 1);
        push("t1_pulse_width", 4);
        s = cyc;
        bus.lane_enable = 2'b01;
        wait_lvl(0, 0, 1'b1, 5, rise);   sb_check(rise - s);
        wait_lvl(0, 0, 1'b0, 10, fall);  sb_check(fall - rise);
        while (cyc < s + 10) tick(1);
        bus.gt_reset_rx_done[0] = 1'b1;
        while (cyc < s + 20) tick(1);
        push("t1_up_delay_2to3", 1);
        push("t1_retry", 0);
        push("t1_lane1_idle", 0);
        bus.phy_rx_block_lock[0] = 1'b1;
        s = cyc;
        wait_lvl(1, 0, 1'b1, 6, at);
        sb_check((at - s >= 2 && at - s <= 3) ? 32'd1 : 32'd0);
        sb_check(bus.retry_count[7:0]);
        sb_check(lane_snap(1));

        // 2: lock timeouts up to the retry limit
        push("t2_disable_idle", 0);
        bus.lane_enable = 2'b00;
        tick(1);
        sb_check(lane_snap(0));
        bus.gt_reset_rx_done[0]  = 1'b0;
        bus.phy_rx_block_lock[0] = 1'b0;
        tick(3);
        push("t2_spacing_1", 74);
        push("t2_spacing_2", 74);
        push("t2_fail_after_3rd", 54);
        push("t2_retry", 3);
        push("t2_no_4th_pulse", 0);
        push("t2_fail_held", 1);
        push("t2_disable_clears", 0);
        bus.lane_enable = 2'b01;
        wait_lvl(0, 0, 1'b1, 5, r1);
        wait_lvl(0, 0, 1'b0, 10, at);
        wait_lvl(0, 0, 1'b1, 100, r2);
        wait_lvl(0, 0, 1'b0, 10, at);
        wait_lvl(0, 0, 1'b1, 100, r3);
        sb_check(r2 - r1);
        sb_check(r3 - r2);
        wait_lvl(2, 0, 1'b1, 100, fl);
        sb_check(fl - r3);
        sb_check(bus.retry_count[7:0]);
        seen = 0;
        repeat (100) begin
            tick(1);
            if (bus.gt_reset_rx_datapath[0]) seen = 1;
        end
        sb_check(seen);
        sb_check(bus.link_fail[0]);
        bus.lane_enable = 2'b00;
        tick(1);
        sb_check(lane_snap(0));

        // 3: one-cycle lock glitch in UP
        bus.gt_reset_rx_done[0]  = 1'b1;
        bus.phy_rx_block_lock[0] = 1'b1;
        tick(3);
        push("t3_up", 1);
        push("t3_retry_fresh", 0);
        bus.lane_enable = 2'b01;
        wait_lvl(1, 0, 1'b1, 30, at);
        sb_check(bus.link_up[0]);
        sb_check(bus.retry_count[7:0]);
        push("t3_drop_latency", 3);
        push("t3_retry", 1);
        push("t3_holdoff", 20);
`ifdef ETH_LINK_SUPERVISOR_STATS_EN
        push("t3_drop_count", 1);
`endif
        g = cyc;
        bus.phy_rx_block_lock[0] = 1'b0;
        tick(1);
        bus.phy_rx_block_lock[0] = 1'b1;
        wait_lvl(1, 0, 1'b0, 6, fall);
        sb_check(fall - g);
        sb_check(bus.retry_count[7:0]);
        wait_lvl(0, 0, 1'b1, 40, rise);
        sb_check(rise - fall);
`ifdef ETH_LINK_SUPERVISOR_STATS_EN
        sb_check(bus.link_drop_count[15:0]);
`endif

        // 4: high BER 7 cycles tolerated, 8 cycles is a drop
        push("t4_up_again", 1);
        push("t4_ber7_stays_up", 0);
        push("t4_ber7_retry", 1);
        wait_lvl(1, 0, 1'b1, 30, at);
        sb_check(bus.link_up[0]);
        bus.phy_rx_high_ber[0] = 1'b1;
        tick(7);
        bus.phy_rx_high_ber[0] = 1'b0;
        seen = 0;
        repeat (6) begin
            tick(1);
            if (!bus.link_up[0]) seen = 1;
        end
        sb_check(seen);
        sb_check(bus.retry_count[7:0]);
        push("t4_ber8_drop_at", 10);
        push("t4_ber8_retry", 2);
`ifdef ETH_LINK_SUPERVISOR_STATS_EN
        push("t4_drop_count", 2);
`endif
        b = cyc;
        bus.phy_rx_high_ber[0] = 1'b1;
        tick(8);
        bus.phy_rx_high_ber[0] = 1'b0;
        wait_lvl(1, 0, 1'b0, 6, fall);
        sb_check(fall - b);
        sb_check(bus.retry_count[7:0]);
`ifdef ETH_LINK_SUPERVISOR_STATS_EN
        sb_check(bus.link_drop_count[15:0]);
`endif

        // 5: abandon a reset pulse, then block reset while UP
        bus.lane_enable = 2'b00;
        tick(1);
        push("t5_mid_pulse", 1);
        push("t5_abandon_pulse", 0);
`ifdef ETH_LINK_SUPERVISOR_STATS_EN
        push("t5_drops_kept", 2);
`endif
        bus.lane_enable = 2'b01;
        wait_lvl(0, 0, 1'b1, 5, rise);
        tick(1);
        sb_check(bus.gt_reset_rx_datapath[0]);
        bus.lane_enable = 2'b00;
        tick(1);
        sb_check(lane_snap(0));
`ifdef ETH_LINK_SUPERVISOR_STATS_EN
        sb_check(bus.link_drop_count[15:0]);
`endif
        push("t5_up_before_rst", 1);
        push("t5_rst_all_zero", 0);
`ifdef ETH_LINK_SUPERVISOR_STATS_EN
        push("t5_rst_drops_zero", 0);
`endif
        bus.lane_enable = 2'b01;
        wait_lvl(1, 0, 1'b1, 30, at);
        sb_check(bus.link_up[0]);
        rst = 1'b1;
        tick(1);
        sb_check({10'd0, bus.gt_reset_rx_datapath, bus.link_up, bus.link_fail, bus.retry_count});
`ifdef ETH_LINK_SUPERVISOR_STATS_EN
        sb_check(bus.link_drop_count);
`endif
        rst = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
